// File: rtl/serial_sub.sv
// Multi-cycle subtractor: result = a - b - bin, BPC bits per clock, LSB slice first.
// Valid/ready on both sides; borrow-out, signed overflow and zero flags are registered with the result.
module serial_sub #(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             bout,
    output logic             ovf,
    output logic             zero,
    output logic             busy
);

    // state | meaning
    // IDLE  | ready for a new operand set
    // RUN   | one BPC-bit slice per edge, N edges in total
    // DONE  | result and flags valid, waiting for out_ready
    localparam int N  = (BPC > 0) ? WIDTH / BPC : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH < 2) || (BPC < 1) || (BPC > WIDTH) || ((WIDTH % BPC) != 0)) begin : g_bad_params
            $error("serial_sub: WIDTH must be >= 2 and BPC must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_sh, b_sh, d_sh;
    logic               a_msb, b_msb, borrow;
    logic [CW-1:0]      cnt;
    logic [BPC-1:0]     slice_d;
    logic               slice_c;
    logic [WIDTH+BPC-1:0] d_cat;
    logic [WIDTH-1:0]   d_nxt;
    logic               last;

    // BPC full-subtractor cells rippling the borrow LSB to MSB within the slice
    always_comb begin : slice_cells
        logic c;
        slice_d = '0;
        c       = borrow;
        for (int i = 0; i < BPC; i++) begin
            slice_d[i] = a_sh[i] ^ b_sh[i] ^ c;
            c          = (~a_sh[i] & b_sh[i]) | (~(a_sh[i] ^ b_sh[i]) & c);
        end
        slice_c = c;
    end

    // New slice enters at the top so that after N slices the LSB slice sits at bit 0
    assign d_cat = {slice_d, d_sh};
    assign d_nxt = d_cat[WIDTH+BPC-1:BPC];
    assign last  = (cnt == CW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            d_sh   <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            borrow <= 1'b0;
            cnt    <= '0;
            result <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                        borrow <= bin;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> BPC;
                    b_sh   <= b_sh >> BPC;
                    d_sh   <= d_nxt;
                    borrow <= slice_c;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        result <= d_nxt;
                        bout   <= slice_c;
                        ovf    <= (a_msb ^ b_msb) & (a_msb ^ d_nxt[WIDTH-1]);
                        zero   <= (d_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
